// File: rtl/enemy_spawner_if.sv
// Spawn request channel from the enemy spawner to the enemy manager (valid/ready plus payload).
interface enemy_spawner_if #(
    parameter int unsigned SW = 3
);
    logic          spawn_valid;
    logic          spawn_ready;
    logic [9:0]    spawn_x;
    logic [1:0]    spawn_type;
    logic [SW-1:0] spawn_slot;

    modport master (
        output spawn_valid,
        output spawn_x,
        output spawn_type,
        output spawn_slot,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_x,
        input  spawn_type,
        input  spawn_slot,
        output spawn_ready
    );
endinterface

// File: rtl/enemy_spawner.sv
// Frame-paced enemy spawner: draws x/type from the LFSR word, scans for a free slot, issues a request.
// Optional difficulty ramp (shrinking spawn interval) is enabled by defining SPAWN_RAMP_EN.
module enemy_spawner #(
    parameter int unsigned RAND_W        = 16,
    parameter int unsigned SLOT_NUM      = 8,
    parameter int unsigned X_MAX         = 599,
    parameter int unsigned INTERVAL_INIT = 60,
    parameter int unsigned INTERVAL_MIN  = 15,
    parameter int unsigned RAMP_STEP     = 8,
    parameter int unsigned RAMP_DEC      = 4
) (
    input  logic                clk_vga,
    input  logic                rst_n,
    input  logic                game_run,
    input  logic                frame_tick,
    input  logic [RAND_W-1:0]   rand_i,
    input  logic [SLOT_NUM-1:0] slot_busy,
    enemy_spawner_if.master     spawn,
    output logic                drop_pulse
);

    localparam int unsigned SW = $clog2(SLOT_NUM);
    localparam int unsigned CW = $clog2(INTERVAL_INIT + 1);

    // Parameter sanity; the ramp parameters are checked even when the ramp is compiled out.
    if (RAND_W < 13 || SLOT_NUM < 2 || (SLOT_NUM & (SLOT_NUM - 1)) != 0 ||
        X_MAX < 511 || X_MAX > 1023 || INTERVAL_INIT == 0 ||
        INTERVAL_MIN == 0 || INTERVAL_MIN > INTERVAL_INIT ||
        RAMP_STEP == 0 || RAMP_DEC == 0) begin : g_param_check
        $error("enemy_spawner: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, PICK, SCAN, ISSUE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [SW-1:0] nscan_q, nscan_d;
    logic [9:0]    x_q, x_d;
    logic [1:0]    type_q, type_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;

    logic [CW-1:0] reload_c;
    logic          xfer_c;
    logic          slot_free_c;
    logic          scan_last_c;
    logic [9:0]    xr_c;
    logic [9:0]    x_pick_c;
    logic          unused_rand_c;

    assign xfer_c        = valid_q && spawn.spawn_ready;
    assign slot_free_c   = !slot_busy[idx_q];
    assign scan_last_c   = (nscan_q == SW'(SLOT_NUM - 1));
    assign xr_c          = rand_i[9:0];
    assign x_pick_c      = ({1'b0, xr_c} > 11'(X_MAX)) ? 10'(11'(xr_c) - 11'(X_MAX + 1)) : xr_c;
    assign unused_rand_c = ^rand_i[RAND_W-3:10];

`ifdef SPAWN_RAMP_EN
    localparam int unsigned KW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;

    logic [KW-1:0] nspawn_q, nspawn_d;
    logic [CW-1:0] reload_q, reload_d;
    logic [CW-1:0] reload_dec_c;
    logic          ramp_step_c;

    assign ramp_step_c  = xfer_c && (nspawn_q == KW'(RAMP_STEP - 1));
    assign reload_dec_c = (32'(reload_q) >= INTERVAL_MIN + RAMP_DEC) ?
                          CW'(32'(reload_q) - RAMP_DEC) : CW'(INTERVAL_MIN);
    // The transfer that completes a step already reloads with the shortened interval.
    assign reload_c     = ramp_step_c ? reload_dec_c : reload_q;

    always_comb begin
        nspawn_d = nspawn_q;
        reload_d = reload_q;
        if (!game_run) begin
            nspawn_d = '0;
            reload_d = CW'(INTERVAL_INIT);
        end else if (xfer_c) begin
            nspawn_d = ramp_step_c ? '0 : KW'(nspawn_q + 1'b1);
            reload_d = reload_c;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            nspawn_q <= '0;
            reload_q <= CW'(INTERVAL_INIT);
        end else begin
            nspawn_q <= nspawn_d;
            reload_q <= reload_d;
        end
    end
`else
    assign reload_c = CW'(INTERVAL_INIT);
`endif

    always_ff @(posedge clk_vga) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: game_run low overrides every other event.
    always_comb begin
        state_d = state_q;
        if (!game_run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (frame_tick && cnt_q == CW'(1)) state_d = PICK;
                PICK:    state_d = SCAN;
                SCAN:    if (slot_free_c) state_d = ISSUE;
                         else if (scan_last_c) state_d = IDLE;
                ISSUE:   if (xfer_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nscan_d = nscan_q;
        x_d     = x_q;
        type_d  = type_q;
        slot_d  = slot_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        if (!game_run) begin
            cnt_d   = CW'(INTERVAL_INIT);
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_tick) cnt_d = CW'(cnt_q - 1'b1);
                end
                PICK: begin
                    x_d     = x_pick_c;
                    type_d  = rand_i[RAND_W-1:RAND_W-2];
                    idx_d   = rand_i[SW-1:0];
                    nscan_d = '0;
                end
                SCAN: begin
                    if (slot_free_c) begin
                        slot_d  = idx_q;
                        valid_d = 1'b1;
                    end else begin
                        idx_d   = (idx_q == SW'(SLOT_NUM - 1)) ? '0 : SW'(idx_q + 1'b1);
                        nscan_d = SW'(nscan_q + 1'b1);
                        if (scan_last_c) begin
                            drop_d = 1'b1;
                            cnt_d  = reload_c;
                        end
                    end
                end
                ISSUE: begin
                    if (xfer_c) begin
                        valid_d = 1'b0;
                        cnt_d   = reload_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            cnt_q   <= CW'(INTERVAL_INIT);
            idx_q   <= '0;
            nscan_q <= '0;
            x_q     <= '0;
            type_q  <= '0;
            slot_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nscan_q <= nscan_d;
            x_q     <= x_d;
            type_q  <= type_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign spawn.spawn_valid = valid_q;
    assign spawn.spawn_x     = x_q;
    assign spawn.spawn_type  = type_q;
    assign spawn.spawn_slot  = slot_q;
    assign drop_pulse        = drop_q;

endmodule
